// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage valid bits, register load enables,
// stall/bubble/flush resolution and post-reset fetch hold. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int RST_HOLD = 4,
  parameter int PW       = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       if_ready,
  input  logic       ld_use,
  input  logic       stall_ex,
  input  logic       stall_mem,
  input  logic       redir_req,
  input  logic       trap_req,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       en_ifid,
  output logic       en_idex,
  output logic       en_exmem,
  output logic       en_memwb,
  output logic       v_id,
  output logic       v_ex,
  output logic       v_mem,
  output logic       v_wb,
  output logic       kill_ex,
  output logic       redir_ack
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PW-1:0] perf_stall,
  output logic [PW-1:0] perf_flush,
  output logic [PW-1:0] perf_ret
`endif
);

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_REDIR = 2'd1,
    PC_TRAP  = 2'd2
  } pc_sel_e;

  localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

  if (RST_HOLD < 0 || RST_HOLD > 255) begin : g_bad_hold
    $error("pipe_ctrl: RST_HOLD must be in 0..255");
  end
  if (PW < 1) begin : g_bad_pw
    $error("pipe_ctrl: PW must be at least 1");
  end

  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic       v_id_q, v_id_d;
  logic       v_ex_q, v_ex_d;
  logic       v_mem_q, v_mem_d;
  logic       v_wb_q, v_wb_d;

  logic    boot;
  logic    mem_hold, ex_hold, id_hold, if_hold;
  logic    trap, redirect;
  pc_sel_e pc_sel_w;

  // Hold chain: a held stage also holds every stage upstream of it.
  always_comb begin
    boot     = (boot_cnt_q != 8'd0);
    mem_hold = stall_mem & v_mem_q;
    ex_hold  = mem_hold | (stall_ex & v_ex_q);
    id_hold  = ex_hold | (ld_use & v_id_q);
    if_hold  = id_hold | ~if_ready | boot;
    trap     = trap_req & v_mem_q & ~stall_mem;
    redirect = redir_req & v_ex_q & ~ex_hold & ~trap;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    v_wb_d     = 1'b0;
    v_mem_d    = 1'b0;
    v_ex_d     = 1'b0;
    v_id_d     = 1'b0;
    pc_sel_w   = PC_SEQ;

    if (boot) begin
      boot_cnt_d = boot_cnt_q - 8'd1;
    end

    // A held stage keeps its valid bit; an unheld stage behind a held one takes a bubble.
    v_wb_d  = v_mem_q & ~mem_hold & ~trap;
    v_mem_d = mem_hold ? v_mem_q : (v_ex_q & ~ex_hold & ~trap);

    if (trap) begin
      v_ex_d = 1'b0;
    end else if (ex_hold) begin
      v_ex_d = v_ex_q;
    end else begin
      v_ex_d = v_id_q & ~id_hold & ~redirect;
    end

    if (trap || redirect) begin
      v_id_d = 1'b0;
    end else if (id_hold) begin
      v_id_d = v_id_q;
    end else begin
      v_id_d = if_ready & ~boot;
    end

    if (trap) begin
      pc_sel_w = PC_TRAP;
    end else if (redirect) begin
      pc_sel_w = PC_REDIR;
    end
  end

  // Control outputs are suppressed for as long as reset is asserted.
  always_comb begin
    pc_en     = rstn & (trap | redirect | ~if_hold);
    pc_sel    = rstn ? pc_sel_w : PC_SEQ;
    en_memwb  = rstn;
    en_exmem  = rstn & ~mem_hold;
    en_idex   = rstn & ~ex_hold;
    en_ifid   = rstn & ~id_hold;
    kill_ex   = rstn & trap & v_ex_q;
    redir_ack = rstn & redirect;
    v_id      = v_id_q;
    v_ex      = v_ex_q;
    v_mem     = v_mem_q;
    v_wb      = v_wb_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      boot_cnt_q <= HOLD_INIT;
      v_id_q     <= 1'b0;
      v_ex_q     <= 1'b0;
      v_mem_q    <= 1'b0;
      v_wb_q     <= 1'b0;
    end else begin
      boot_cnt_q <= boot_cnt_d;
      v_id_q     <= v_id_d;
      v_ex_q     <= v_ex_d;
      v_mem_q    <= v_mem_d;
      v_wb_q     <= v_wb_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] perf_stall_q, perf_flush_q, perf_ret_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_ret_q   <= '0;
    end else begin
      if (id_hold)          perf_stall_q <= perf_stall_q + 1'b1;
      if (trap || redirect) perf_flush_q <= perf_flush_q + 1'b1;
      if (v_wb_q)           perf_ret_q   <= perf_ret_q + 1'b1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_ret   = perf_ret_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: the driver queues hand-computed expected outputs,
// a monitor pops and compares them once per cycle on the falling edge.
module tb_pipe_ctrl;

  logic       clk;
  logic       rstn;
  logic       if_ready, ld_use, stall_ex, stall_mem, redir_req, trap_req;
  logic       pc_en;
  logic [1:0] pc_sel;
  logic       en_ifid, en_idex, en_exmem, en_memwb;
  logic       v_id, v_ex, v_mem, v_wb;
  logic       kill_ex, redir_ack;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush, perf_ret;
`endif

  pipe_ctrl #(.RST_HOLD(4), .PW(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .if_ready  (if_ready),
    .ld_use    (ld_use),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .redir_req (redir_req),
    .trap_req  (trap_req),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .en_ifid   (en_ifid),
    .en_idex   (en_idex),
    .en_exmem  (en_exmem),
    .en_memwb  (en_memwb),
    .v_id      (v_id),
    .v_ex      (v_ex),
    .v_mem     (v_mem),
    .v_wb      (v_wb),
    .kill_ex   (kill_ex),
    .redir_ack (redir_ack)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_flush(perf_flush),
    .perf_ret  (perf_ret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: {pc_en, pc_sel[1:0], en_ifid, en_idex, en_exmem, en_memwb,
  //                 kill_ex, redir_ack, v_id, v_ex, v_mem, v_wb}
  typedef struct packed {
    logic [31:0] idx;
    logic [12:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_idx  = 0;
  bit   drive_done = 1'b0;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (pc_en,pc_sel,en_ifid,en_idex,en_exmem,en_memwb,kill,ack,v_id,v_ex,v_mem,v_wb)",
               name, got, exp);
    end
  endtask

  // Input word: {rstn, if_ready, ld_use, stall_ex, stall_mem, redir_req, trap_req}
  task automatic apply(input logic [6:0] in, input logic [12:0] exp);
    exp_t e;
    {rstn, if_ready, ld_use, stall_ex, stall_mem, redir_req, trap_req} = in;
    e.idx = 32'(vec_idx);
    e.exp = exp;
    exp_q.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    logic [12:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {pc_en, pc_sel, en_ifid, en_idex, en_exmem, en_memwb,
               kill_ex, redir_ack, v_id, v_ex, v_mem, v_wb};
        check($sformatf("vec%0d", e.idx), got, e.exp);
      end
    end
  end

  initial begin
    {rstn, if_ready, ld_use, stall_ex, stall_mem, redir_req, trap_req} = 7'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset: outputs forced low even with requests pending.
    apply(7'b0_1_0_0_0_1_1, 13'b0_00_0000_00_0000);
    // Boot hold: four cycles with fetch off, PC loads at cycle 4, v_id at cycle 5.
    apply(7'b1_1_0_0_0_0_0, 13'b0_00_1111_00_0000);
    apply(7'b1_1_0_0_0_0_0, 13'b0_00_1111_00_0000);
    apply(7'b1_1_0_0_0_0_0, 13'b0_00_1111_00_0000);
    apply(7'b1_1_0_0_0_0_0, 13'b0_00_1111_00_0000);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_0000);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1000);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1100);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1110);
    // Load-use: IF/ID held, bubble into EX.
    apply(7'b1_1_1_0_0_0_0, 13'b0_00_0111_00_1111);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1011);
    // Multi-cycle EX for three cycles.
    apply(7'b1_1_0_1_0_0_0, 13'b0_00_0011_00_1101);
    apply(7'b1_1_0_1_0_0_0, 13'b0_00_0011_00_1100);
    apply(7'b1_1_0_1_0_0_0, 13'b0_00_0011_00_1100);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1100);
    // Redirect accepted immediately, flushes ID and EX.
    apply(7'b1_1_0_0_0_1_0, 13'b1_01_1111_01_1110);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_0011);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1001);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1100);
    // Deferred redirect: held off by a MEM stall for two cycles.
    apply(7'b1_1_0_0_1_1_0, 13'b0_00_0001_00_1110);
    apply(7'b1_1_0_0_1_1_0, 13'b0_00_0001_00_1110);
    apply(7'b1_1_0_0_0_1_0, 13'b1_01_1111_01_1110);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_0011);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1001);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_1100);
    // Trap and redirect together: trap wins and flushes everything.
    apply(7'b1_1_0_0_0_1_1, 13'b1_10_1111_10_1110);
    apply(7'b1_1_0_0_0_0_0, 13'b1_00_1111_00_0000);
    // Fetch not ready.
    apply(7'b1_0_0_0_0_0_0, 13'b0_00_1111_00_1000);
    // Stall on an invalid MEM stage is ignored.
    apply(7'b1_1_0_0_1_0_0, 13'b1_00_1111_00_0100);
    // Stall on invalid EX ignored; trap blocked by a MEM stall.
    apply(7'b1_1_0_1_1_0_1, 13'b0_00_0001_00_1010);
    // Reset mid-stall discards all state, then boot hold restarts.
    apply(7'b0_1_0_0_1_0_0, 13'b0_00_0000_00_1010);
    apply(7'b1_1_0_0_0_0_0, 13'b0_00_1111_00_0000);
    drive_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (drive_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d pending expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencer for the 5-stage core pipeline (IF, ID, EX, MEM, WB).
- Owns the valid bit of each pipeline register: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives the load enable of every pipeline register and of the PC register. These registers are built from the team's enable flip-flop.
- Resolves stall sources, branch redirects and traps into per-stage enable, bubble and flush decisions, and holds fetch off for a fixed interval after reset.

Parameters:
- RST_HOLD, 4: cycles after reset release during which fetch is held off. Legal range 0..255.
- PW, 32: width of the performance counters; used only with the optional feature.

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- if_ready  input  1  fetch data valid this cycle
- ld_use  input  1  load-use hazard detected in ID
- stall_ex  input  1  EX multi-cycle unit busy
- stall_mem  input  1  LSU waiting on memory
- redir_req  input  1  branch/jump redirect from EX; held by the source until accepted
- trap_req  input  1  exception/interrupt taken at MEM
- pc_en  output  1  PC register load enable
- pc_sel  output  2  0 = sequential, 1 = redirect target, 2 = trap vector
- en_ifid, en_idex, en_exmem, en_memwb  output  1 each  pipeline register load enables
- v_id, v_ex, v_mem, v_wb  output  1 each  valid bit of the instruction held in IF/ID, ID/EX, EX/MEM, MEM/WB
- kill_ex  output  1  abort the multi-cycle op in EX
- redir_ack  output  1  redirect accepted this cycle

Behaviour:
- Reset (rstn=0 at a clk edge): v_* <= 0; boot counter <= RST_HOLD.
- While rstn=0, all enables, pc_en, kill_ex and redir_ack are forced to 0, and pc_sel = 0.
- boot = (boot counter != 0). The counter decrements once per cycle to 0 and then stays there.
- Combinational terms, from the current state and inputs:
  - mem_hold = stall_mem & v_mem
  - ex_hold = mem_hold | (stall_ex & v_ex)
  - id_hold = ex_hold | (ld_use & v_id)
  - if_hold = id_hold | !if_ready | boot
  - trap = trap_req & v_mem & !stall_mem
  - redirect = redir_req & v_ex & !ex_hold & !trap
- Enables:
  - en_memwb = 1
  - en_exmem = !mem_hold
  - en_idex = !ex_hold
  - en_ifid = !id_hold
  - pc_en = trap | redirect | !if_hold
- PC select: pc_sel = 2 if trap, else 1 if redirect, else 0. Trap has priority over redirect.
- Outputs: kill_ex = trap & v_ex; redir_ack = redirect.
- Next-state valid bits (registered, single-cycle latency):
  - v_wb <= v_mem & !mem_hold & !trap. The trapping instruction does not retire.
  - v_mem <= mem_hold ? v_mem : (v_ex & !ex_hold & !trap)
  - v_ex <= trap ? 0 : ex_hold ? v_ex : (v_id & !id_hold & !redirect)
  - v_id <= (trap | redirect) ? 0 : id_hold ? v_id : (if_ready & !boot)
- Bubble rule: when stage N is held and stage N+1 is not, N+1 loads a bubble. Its data is don't-care and its valid bit is 0.
- A stall input on an invalid stage is ignored.
- redir_req while EX is held is not accepted. The source keeps it asserted and it is accepted in the first cycle EX advances.
- trap and redirect in the same cycle: trap wins, redir_ack = 0, and the EX instruction is flushed.
- RST_HOLD = 0: fetch may start the cycle after reset release.
- Reset mid-stall or mid-flush: all state is discarded on the same edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, three extra PW-bit output counters are present, reset to 0 and wrapping at 2^PW:
  - perf_stall: increments each cycle with id_hold = 1
  - perf_flush: increments each cycle with trap | redirect
  - perf_ret: increments each cycle in which v_wb is 1
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Boot hold: RST_HOLD=4, if_ready=1 from reset release -> pc_en=0 for cycles 0..3 after release, pc_en=1 at cycle 4, v_id=1 at cycle 5.
- Load-use: ld_use=1 for 1 cycle with v_id=1 -> en_ifid=0 and pc_en=0 that cycle; next cycle v_ex=0 (bubble) and v_id still 1.
- Multi-cycle EX: stall_ex=1 for 3 cycles -> en_idex=en_ifid=pc_en=0 for 3 cycles; v_mem=0 for 3 consecutive cycles, then resumes.
- Redirect: redir_req=1 with v_ex=1 and no stalls -> redir_ack=1, pc_sel=1, pc_en=1; next cycle v_id=0 and v_ex=0.
- Deferred redirect: redir_req=1 during stall_mem=1 (v_mem=1) for 2 cycles -> redir_ack=0 for those 2 cycles, redir_ack=1 in the cycle stall_mem drops.
- Trap vs redirect: trap_req=1 (v_mem=1) and redir_req=1 in the same cycle -> pc_sel=2, redir_ack=0, kill_ex=1; next cycle v_id=v_ex=v_mem=v_wb=0.
